// File: rtl/processing_unit_if.sv
// Strobe, select and data bus between the control unit / memory side and the
// RISC machine datapath (processing_unit).
interface processing_unit_if #(
    parameter int word_size = 8,
    parameter int sel1_size = 3,
    parameter int sel2_size = 2
);
    logic                 Load_R0;
    logic                 Load_R1;
    logic                 Load_R2;
    logic                 Load_R3;
    logic                 Load_PC;
    logic                 Inc_PC;
    logic                 Load_IR;
    logic                 Load_Add_R;
    logic                 Load_Reg_Y;
    logic                 Load_Reg_Z;
    logic [sel1_size-1:0] Sel_Bus_1_Mux;
    logic [sel2_size-1:0] Sel_Bus_2_Mux;
    logic [word_size-1:0] mem_word;

    logic [word_size-1:0] instruction;
    logic                 Zflag;
    logic [word_size-1:0] address;
    logic [word_size-1:0] Bus_1;

    // Control unit and memory side: drives strobes, selects and read data.
    modport master (
        output Load_R0, Load_R1, Load_R2, Load_R3,
        output Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z,
        output Sel_Bus_1_Mux, Sel_Bus_2_Mux, mem_word,
        input  instruction, Zflag, address, Bus_1
    );

    // Datapath side.
    modport slave (
        input  Load_R0, Load_R1, Load_R2, Load_R3,
        input  Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z,
        input  Sel_Bus_1_Mux, Sel_Bus_2_Mux, mem_word,
        output instruction, Zflag, address, Bus_1
    );
endinterface

// File: rtl/processing_unit.sv
// Datapath of the RISC stored-program machine: register file R0-R3, PC, IR,
// address register, ALU operand Y, zero flag Z, two bus muxes and the ALU.
module processing_unit #(
    parameter int word_size = 8,
    parameter int op_size   = 4,
    parameter int sel1_size = 3,
    parameter int sel2_size = 2
) (
    input logic             clk,
    input logic             rst,
    processing_unit_if.slave pu
);

    localparam logic [op_size-1:0] OP_ADD = op_size'(1);
    localparam logic [op_size-1:0] OP_SUB = op_size'(2);
    localparam logic [op_size-1:0] OP_AND = op_size'(3);
    localparam logic [op_size-1:0] OP_NOT = op_size'(4);

    localparam logic [sel1_size-1:0] BUS1_R0 = sel1_size'(0);
    localparam logic [sel1_size-1:0] BUS1_R1 = sel1_size'(1);
    localparam logic [sel1_size-1:0] BUS1_R2 = sel1_size'(2);
    localparam logic [sel1_size-1:0] BUS1_R3 = sel1_size'(3);
    localparam logic [sel1_size-1:0] BUS1_PC = sel1_size'(4);

    localparam logic [sel2_size-1:0] BUS2_ALU = sel2_size'(0);
    localparam logic [sel2_size-1:0] BUS2_B1  = sel2_size'(1);
    localparam logic [sel2_size-1:0] BUS2_MEM = sel2_size'(2);

    logic [word_size-1:0] r_file [4];
    logic [word_size-1:0] pc;
    logic [word_size-1:0] ir;
    logic [word_size-1:0] add_r;
    logic [word_size-1:0] reg_y;
    logic                 reg_z;

    logic [word_size-1:0] bus_1;
    logic [word_size-1:0] bus_2;
    logic [word_size-1:0] alu_out;
    logic                 alu_zero;
    logic [op_size-1:0]   opcode;
    logic [3:0]           load_r;

    assign opcode = ir[word_size-1 -: op_size];
    assign load_r = {pu.Load_R3, pu.Load_R2, pu.Load_R1, pu.Load_R0};

    // NOTE: every always_comb output gets a default before the case, so an
    // unlisted select value can never leave it unassigned and infer a latch.
    always_comb begin
        bus_1 = '0;
        case (pu.Sel_Bus_1_Mux)
            BUS1_R0: bus_1 = r_file[0];
            BUS1_R1: bus_1 = r_file[1];
            BUS1_R2: bus_1 = r_file[2];
            BUS1_R3: bus_1 = r_file[3];
            BUS1_PC: bus_1 = pc;
            default: bus_1 = '0;
        endcase
    end

    // ALU: data_1 is the Y operand register, data_2 is Bus_1.
    always_comb begin
        alu_out = '0;
        case (opcode)
            OP_ADD:  alu_out = reg_y + bus_1;
            OP_SUB:  alu_out = bus_1 - reg_y;
            OP_AND:  alu_out = reg_y & bus_1;
            OP_NOT:  alu_out = ~bus_1;
            default: alu_out = '0;
        endcase
    end

    assign alu_zero = (alu_out == '0);

    always_comb begin
        bus_2 = '0;
        case (pu.Sel_Bus_2_Mux)
            BUS2_ALU: bus_2 = alu_out;
            BUS2_B1:  bus_2 = bus_1;
            BUS2_MEM: bus_2 = pu.mem_word;
            default:  bus_2 = '0;
        endcase
    end

    // NOTE: the register file is four flops per bit, not a RAM macro, so it
    // takes the asynchronous reset like every other architectural register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_file[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load_r[i]) begin
                    r_file[i] <= bus_2;
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // same pre-edge Bus_2 value when several strobes fire together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else if (pu.Load_PC) begin
            pc <= bus_2;
        end else if (pu.Inc_PC) begin
            pc <= pc + word_size'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir <= '0;
        end else if (pu.Load_IR) begin
            ir <= bus_2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_r <= '0;
        end else if (pu.Load_Add_R) begin
            add_r <= bus_2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_y <= '0;
        end else if (pu.Load_Reg_Y) begin
            reg_y <= bus_2;
        end
    end

    // Z sees the ALU result formed from this cycle's Y, Bus_1 and IR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_z <= 1'b0;
        end else if (pu.Load_Reg_Z) begin
            reg_z <= alu_zero;
        end
    end

    assign pu.instruction = ir;
    assign pu.Zflag       = reg_z;
    assign pu.address     = add_r;
    assign pu.Bus_1       = bus_1;

endmodule

// File: tb/tb_processing_unit.sv
// Self-checking bench for processing_unit: directed instruction-level vectors,
// a register-level reference model and literal expectations for key results.
module tb_processing_unit;

    localparam logic [9:0] NONE   = 10'b0000000000;
    localparam logic [9:0] L_R0   = 10'b0000000001;
    localparam logic [9:0] L_R1   = 10'b0000000010;
    localparam logic [9:0] L_R2   = 10'b0000000100;
    localparam logic [9:0] L_R3   = 10'b0000001000;
    localparam logic [9:0] L_PC   = 10'b0000010000;
    localparam logic [9:0] INC_PC = 10'b0000100000;
    localparam logic [9:0] L_IR   = 10'b0001000000;
    localparam logic [9:0] L_ADDR = 10'b0010000000;
    localparam logic [9:0] L_Y    = 10'b0100000000;
    localparam logic [9:0] L_Z    = 10'b1000000000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    processing_unit_if pu_bus ();

    processing_unit dut (
        .clk (clk),
        .rst (rst),
        .pu  (pu_bus)
    );

    // Architectural state as the programmer sees it.
    logic [7:0] m_r [4];
    logic [7:0] m_pc, m_ir, m_addr, m_y;
    logic       m_z;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_bus1(input logic [2:0] sel);
        if (sel < 3'd4) return m_r[sel[1:0]];
        if (sel == 3'd4) return m_pc;
        return 8'h00;
    endfunction

    function automatic logic [7:0] m_alu(input logic [7:0] b);
        case (m_ir[7:4])
            4'd1:    return m_y + b;
            4'd2:    return b - m_y;
            4'd3:    return m_y & b;
            4'd4:    return ~b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_pc = 8'h00; m_ir = 8'h00; m_addr = 8'h00; m_y = 8'h00; m_z = 1'b0;
    endtask

    // Apply one clock edge of instruction-level semantics to the model.
    task automatic model_clock();
        logic [7:0] b1, b2, alu;
        if (rst !== 1'b1) return;
        b1  = m_bus1(pu_bus.Sel_Bus_1_Mux);
        alu = m_alu(b1);
        case (pu_bus.Sel_Bus_2_Mux)
            2'd0:    b2 = alu;
            2'd1:    b2 = b1;
            2'd2:    b2 = pu_bus.mem_word;
            default: b2 = 8'h00;
        endcase
        if (pu_bus.Load_Reg_Z) m_z = (alu == 8'h00);
        if (pu_bus.Load_R0) m_r[0] = b2;
        if (pu_bus.Load_R1) m_r[1] = b2;
        if (pu_bus.Load_R2) m_r[2] = b2;
        if (pu_bus.Load_R3) m_r[3] = b2;
        if (pu_bus.Load_PC) m_pc = b2;
        else if (pu_bus.Inc_PC) m_pc = m_pc + 8'h01;
        if (pu_bus.Load_IR) m_ir = b2;
        if (pu_bus.Load_Add_R) m_addr = b2;
        if (pu_bus.Load_Reg_Y) m_y = b2;
    endtask

    task automatic drive(input logic [9:0] ld, input logic [2:0] s1, input logic [1:0] s2,
                         input logic [7:0] mw);
        pu_bus.Load_R0       = ld[0];
        pu_bus.Load_R1       = ld[1];
        pu_bus.Load_R2       = ld[2];
        pu_bus.Load_R3       = ld[3];
        pu_bus.Load_PC       = ld[4];
        pu_bus.Inc_PC        = ld[5];
        pu_bus.Load_IR       = ld[6];
        pu_bus.Load_Add_R    = ld[7];
        pu_bus.Load_Reg_Y    = ld[8];
        pu_bus.Load_Reg_Z    = ld[9];
        pu_bus.Sel_Bus_1_Mux = s1;
        pu_bus.Sel_Bus_2_Mux = s2;
        pu_bus.mem_word      = mw;
    endtask

    task automatic step(input logic [9:0] ld, input logic [2:0] s1, input logic [1:0] s2,
                        input logic [7:0] mw);
        drive(ld, s1, s2, mw);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    // Idle cycle that reads one source onto Bus_1 and pins it to a literal.
    task automatic expect_bus1(input string name, input logic [2:0] sel, input logic [7:0] exp);
        drive(NONE, sel, 2'd3, 8'h00);
        #2;
        check(name, pu_bus.Bus_1, exp);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    // Continuous comparison against the model, mid-cycle.
    always @(negedge clk) begin
        check("instruction", pu_bus.instruction, m_ir);
        check("Zflag", {7'd0, pu_bus.Zflag}, {7'd0, m_z});
        check("address", pu_bus.address, m_addr);
        if (!$isunknown(pu_bus.Sel_Bus_1_Mux))
            check("Bus_1", pu_bus.Bus_1, m_bus1(pu_bus.Sel_Bus_1_Mux));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        model_reset();
        drive(NONE, 3'd0, 2'd3, 8'h00);
        repeat (2) @(posedge clk);
        #3;
        check("reset_instruction", pu_bus.instruction, 8'h00);
        check("reset_address", pu_bus.address, 8'h00);
        rst = 1'b1;

        // Fetch of ADD R1,R2 from mem[0].
        step(L_ADDR, 3'd4, 2'd1, 8'h00);
        step(L_IR | INC_PC, 3'd0, 2'd2, 8'h16);
        check("fetch_address", pu_bus.address, 8'h00);
        check("fetch_instruction", pu_bus.instruction, 8'h16);
        expect_bus1("fetch_pc", 3'd4, 8'h01);

        // ADD R1,R2 with wrap: F0 + 20 = 10.
        step(L_R1, 3'd0, 2'd2, 8'hF0);
        step(L_R2, 3'd0, 2'd2, 8'h20);
        step(L_Y, 3'd2, 2'd1, 8'h00);
        step(L_R1 | L_Z, 3'd1, 2'd0, 8'h00);
        expect_bus1("add_r1", 3'd1, 8'h10);
        check("add_zflag", {7'd0, pu_bus.Zflag}, 8'h00);

        // SUB R3,R0 giving zero.
        step(L_R3, 3'd0, 2'd2, 8'h05);
        step(L_R0, 3'd0, 2'd2, 8'h05);
        step(L_IR, 3'd0, 2'd2, 8'h2C);
        check("sub_instruction", pu_bus.instruction, 8'h2C);
        step(L_Y, 3'd0, 2'd1, 8'h00);
        step(L_R3 | L_Z, 3'd3, 2'd0, 8'h00);
        expect_bus1("sub_r3", 3'd3, 8'h00);
        check("sub_zflag", {7'd0, pu_bus.Zflag}, 8'h01);

        // PC wrap and priority of load over increment.
        step(L_PC, 3'd0, 2'd2, 8'hFF);
        expect_bus1("pc_load", 3'd4, 8'hFF);
        step(INC_PC, 3'd0, 2'd3, 8'h00);
        expect_bus1("pc_wrap", 3'd4, 8'h00);
        step(L_PC | INC_PC, 3'd0, 2'd2, 8'h42);
        expect_bus1("pc_priority", 3'd4, 8'h42);

        // Multi-load through the default Bus_1 source, then Bus_2 default.
        step(L_R0 | L_R2, 3'd6, 2'd1, 8'h00);
        expect_bus1("multi_r0", 3'd0, 8'h00);
        expect_bus1("multi_r2", 3'd2, 8'h00);
        step(L_IR, 3'd0, 2'd3, 8'h00);
        check("ir_bus2_zero", pu_bus.instruction, 8'h00);

        // Clear Z with ADD (Y=05 + PC=42), then set it with an undefined opcode.
        step(L_IR, 3'd0, 2'd2, 8'h10);
        step(L_Z, 3'd4, 2'd0, 8'h00);
        check("add_pc_zflag", {7'd0, pu_bus.Zflag}, 8'h00);
        step(L_IR, 3'd0, 2'd2, 8'hF0);
        step(L_Z, 3'd4, 2'd0, 8'h00);
        check("undef_op_zflag", {7'd0, pu_bus.Zflag}, 8'h01);

        // NOT into R1 (~42 = BD), then AND Y=05 with R1 into R2.
        step(L_IR, 3'd0, 2'd2, 8'h40);
        step(L_R1, 3'd4, 2'd0, 8'h00);
        expect_bus1("not_r1", 3'd1, 8'hBD);
        step(L_IR, 3'd0, 2'd2, 8'h30);
        step(L_R2, 3'd1, 2'd0, 8'h00);
        expect_bus1("and_r2", 3'd2, 8'h05);

        // Unknown Bus_1 select while only the PC increments.
        step(INC_PC, 3'bxxx, 2'd3, 8'h00);
        expect_bus1("xsel_pc", 3'd4, 8'h43);
        expect_bus1("xsel_r1", 3'd1, 8'hBD);

        // Mid-cycle reset with loads pending.
        step(L_ADDR, 3'd4, 2'd1, 8'h00);
        check("addr_before_reset", pu_bus.address, 8'h43);
        drive(L_R1 | L_Z | L_PC, 3'd1, 2'd2, 8'h77);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_instruction", pu_bus.instruction, 8'h00);
        check("async_zflag", {7'd0, pu_bus.Zflag}, 8'h00);
        check("async_address", pu_bus.address, 8'h00);
        check("async_r1", pu_bus.Bus_1, 8'h00);
        @(posedge clk);
        #1;
        drive(NONE, 3'd4, 2'd3, 8'h00);
        #1;
        check("held_reset_pc", pu_bus.Bus_1, 8'h00);
        rst = 1'b1;
        step(L_R1, 3'd0, 2'd2, 8'h77);
        expect_bus1("post_reset_r1", 3'd1, 8'h77);
        expect_bus1("post_reset_pc", 3'd4, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/processing_unit.md
# processing_unit

Datapath of the RISC stored-program machine. It sits directly downstream of the control unit. It executes that unit's per-cycle load and select strobes against the register file (R0–R3), PC, IR, address register, ALU operand register Y and zero-flag register Z. It feeds `instruction` and `Zflag` back to the control unit and drives `address` and write data to the external memory.

## Interface
- `word_size`, 8: width of data, address and instruction words.
- `op_size`, 4: opcode field width (instruction[word_size-1 -: op_size]).
- `sel1_size`, 3: Bus_1 select width.
- `sel2_size`, 2: Bus_2 select width.

Ports:
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `Load_R0`, `Load_R1`, `Load_R2`, `Load_R3`  in  1 each: load Rn from Bus_2.
- `Load_PC`  in  1: load PC from Bus_2.
- `Inc_PC`  in  1: PC <= PC + 1.
- `Load_IR`  in  1: load IR from Bus_2.
- `Load_Add_R`  in  1: load address register from Bus_2.
- `Load_Reg_Y`  in  1: load Y from Bus_2.
- `Load_Reg_Z`  in  1: load Z from ALU zero detect.
- `Sel_Bus_1_Mux`  in  3: Bus_1 source select.
- `Sel_Bus_2_Mux`  in  2: Bus_2 source select.
- `mem_word`  in  word_size: memory read data.
- `instruction`  out  word_size: IR contents, to control unit.
- `Zflag`  out  1: Z register, to control unit.
- `address`  out  word_size: address register, to memory.
- `Bus_1`  out  word_size: Bus_1 value; memory write data.

## Operation
- Bus_1 mux (combinational):
  - sel 0–3 selects R0–R3.
  - sel 4 selects PC.
  - sel 5–7 drives 0.
  - Sel_Bus_1_Mux = X must not propagate X into any register that is not being loaded.
- Bus_2 mux (combinational): sel 0 = ALU_out, 1 = Bus_1, 2 = mem_word, 3 = 0.
- ALU (combinational):
  - data_1 = Y, data_2 = Bus_1; opcode = IR[7:4].
  - 0001 ADD: data_1 + data_2.
  - 0010 SUB: data_2 − data_1.
  - 0011 AND: data_1 & data_2.
  - 0100 NOT: ~data_2.
  - All other opcodes: 0.
  - Results are word_size wide, modulo 2^word_size; carry/borrow is discarded.
  - alu_zero = (ALU_out == 0).
- Registers (rising clk):
  - Each register loads independently when its strobe is high; otherwise it holds.
  - Several strobes in one cycle all take effect, each sampling the same Bus_2 value.
- PC priority: Load_PC > Inc_PC > hold.
  - Increment wraps 8'hFF -> 8'h00.
- Z: on Load_Reg_Z, Z <= alu_zero, evaluated with the same-cycle Y, Bus_1 and IR.
- Register-to-register op sequence, as driven upstream:
  - dec cycle: Bus_1 = R[src], Bus_2 = Bus_1, Load_Reg_Y.
  - exe cycle: Bus_1 = R[dst], Bus_2 = ALU_out, Load_R[dst] and Load_Reg_Z.
  - Result: R[dst] <= R[dst] op R[src].
- No internal state machine beyond the registers. Sequencing is owned upstream; this block must produce correct results for any strobe combination.

## Timing
- Reset (rst low, asynchronous): R0–R3, PC, IR, address register, Y and Z all go to 0.
  - Outputs: `instruction` = 0, `Zflag` = 0, `address` = 0, `Bus_1` = value of selected source (0 with sel 0–3).
  - Reset mid-operation discards all in-flight state.
  - First load is the first rising edge after rst deasserts.
- Bus_1, Bus_2, ALU_out and alu_zero are combinational from selects and register outputs, with zero-cycle latency.
- Register outputs, including `instruction`, `Zflag` and `address`, change only at a rising edge, one cycle after the strobe is sampled.
- Memory read: `address` is valid the cycle after Load_Add_R. `mem_word` is expected combinationally in that cycle; external memory latency 0.
- Memory write: `Bus_1` is valid in the same cycle as the control unit's `write` strobe.
- Fetch: fet1 loads address <= PC. fet2 loads IR <= mem_word with PC+1. `instruction` is valid in the dec cycle.

## Test plan
- Reset: preload registers, pulse rst low mid-cycle -> all registers 0 immediately, no clock needed; `address` = 0, `Zflag` = 0.
- Fetch: PC = 0, mem[0] = 8'h16 (ADD R1,R2); drive fet1 then fet2 -> `address` = 0, `instruction` = 8'h16, PC = 1.
- ADD: R1 = 8'hF0, R2 = 8'h20, dec then exe -> R1 = 8'h10 (wrap), Zflag = 0.
- SUB zero: R3 = 8'h05, R0 = 8'h05, IR = 8'h2C, dec (src R0) then exe (dst R3) -> R3 = 0, Zflag = 1.
- PC priority: PC = 8'hFF, Inc_PC alone -> PC = 0. Next cycle Load_PC and Inc_PC with mem_word = 8'h42, Sel2 = 2 -> PC = 8'h42.
- Multi-load / default muxes:
  - Sel1 = 6, Sel2 = 1, Load_R0 and Load_R2 -> R0 = R2 = 0.
  - Sel2 = 3 with Load_IR -> IR = 0.
  - Opcode 4'b1111 with Load_Reg_Z -> Zflag = 1.
